// File: rtl/fox_hoplite_network_interface_if.sv
// Router-side port bundle for the Hoplite network interface.
// Master is the node interface; slave is the router.
interface fox_hoplite_network_interface_if #(
  parameter int PACKET_BITS = 54
);
  logic [PACKET_BITS-1:0] rtr_out_data;
  logic                   rtr_out_valid;
  logic                   rtr_out_ready;
  logic [PACKET_BITS-1:0] rtr_in_data;
  logic                   rtr_in_valid;

  modport master (
    output rtr_out_data,
    output rtr_out_valid,
    input  rtr_out_ready,
    input  rtr_in_data,
    input  rtr_in_valid
  );

  modport slave (
    input  rtr_out_data,
    input  rtr_out_valid,
    output rtr_out_ready,
    output rtr_in_data,
    output rtr_in_valid
  );
endinterface

// File: rtl/fox_hoplite_network_interface.sv
// Node-side packet assembly plus TX/RX packet FIFOs
// between a PicoRV32 node and its Hoplite router.
module fox_hoplite_network_interface #(
  parameter int COORD_BITS           = 1,
  parameter int MULTICAST_GROUP_BITS = 1,
  parameter int MATRIX_TYPE_BITS     = 1,
  parameter int MATRIX_COORD_BITS    = 8,
  parameter int MATRIX_ELEMENT_BITS  = 32,
  parameter int TX_FIFO_DEPTH        = 4,
  parameter int RX_FIFO_DEPTH        = 4
) (
  input  logic clk,
  input  logic reset_n,

  input  logic [COORD_BITS-1:0]           node_x_coord,
  input  logic                            node_x_coord_valid,
  input  logic [COORD_BITS-1:0]           node_y_coord,
  input  logic                            node_y_coord_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] node_multicast_group,
  input  logic                            node_multicast_group_valid,
  input  logic                            node_done_flag,
  input  logic                            node_done_flag_valid,
  input  logic                            node_result_flag,
  input  logic                            node_result_flag_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     node_matrix_type,
  input  logic                            node_matrix_type_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    node_matrix_x_coord,
  input  logic                            node_matrix_x_coord_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    node_matrix_y_coord,
  input  logic                            node_matrix_y_coord_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  node_matrix_element,
  input  logic                            node_matrix_element_valid,
  input  logic                            node_packet_complete,
  output logic                            message_out_ready,

  output logic [MULTICAST_GROUP_BITS-1:0] node_in_multicast_group,
  output logic                            node_in_done_flag,
  output logic                            node_in_result_flag,
  output logic [MATRIX_TYPE_BITS-1:0]     node_in_matrix_type,
  output logic [MATRIX_COORD_BITS-1:0]    node_in_matrix_x_coord,
  output logic [MATRIX_COORD_BITS-1:0]    node_in_matrix_y_coord,
  output logic [MATRIX_ELEMENT_BITS-1:0]  node_in_matrix_element,
  output logic                            message_in_valid,
  output logic                            message_in_available,
  input  logic                            message_in_read,

  fox_hoplite_network_interface_if.master rtr,

  output logic tx_overflow,
  output logic rx_overflow
);

  localparam int PACKET_BITS = 2*COORD_BITS + MULTICAST_GROUP_BITS
    + 2 + MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS
    + MATRIX_ELEMENT_BITS;

  localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
  localparam int RX_CW = RX_AW + 1;

  typedef struct packed {
    logic [COORD_BITS-1:0]           x_coord;
    logic [COORD_BITS-1:0]           y_coord;
    logic [MULTICAST_GROUP_BITS-1:0] multicast_group;
    logic                            done_flag;
    logic                            result_flag;
    logic [MATRIX_TYPE_BITS-1:0]     matrix_type;
    logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord;
    logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord;
    logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element;
  } pkt_t;

  // ---------------- staging ----------------
  pkt_t stage_q;
  pkt_t stage_d;

  // Field writes in the commit cycle land in the pushed word too.
  always_comb begin
    stage_d = stage_q;
    if (node_x_coord_valid)
      stage_d.x_coord = node_x_coord;
    if (node_y_coord_valid)
      stage_d.y_coord = node_y_coord;
    if (node_multicast_group_valid)
      stage_d.multicast_group = node_multicast_group;
    if (node_done_flag_valid)
      stage_d.done_flag = node_done_flag;
    if (node_result_flag_valid)
      stage_d.result_flag = node_result_flag;
    if (node_matrix_type_valid)
      stage_d.matrix_type = node_matrix_type;
    if (node_matrix_x_coord_valid)
      stage_d.matrix_x_coord = node_matrix_x_coord;
    if (node_matrix_y_coord_valid)
      stage_d.matrix_y_coord = node_matrix_y_coord;
    if (node_matrix_element_valid)
      stage_d.matrix_element = node_matrix_element;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      stage_q <= '0;
    else
      stage_q <= stage_d;
  end

  // ---------------- TX FIFO ----------------
  pkt_t             tx_mem [TX_FIFO_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic             tx_full;
  logic             tx_push;
  logic             tx_pop;

  assign tx_full = tx_count == TX_CW'(TX_FIFO_DEPTH);
  assign tx_pop  = rtr.rtr_out_valid
                 & rtr.rtr_out_ready;
  assign tx_push = node_packet_complete
                 & (~tx_full | tx_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push)
        tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)
        tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      tx_count <= tx_count + TX_CW'(tx_push)
                           - TX_CW'(tx_pop);
      if (node_packet_complete && !tx_push)
        tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wr_ptr] <= stage_d;
  end

  assign message_out_ready = reset_n & ~tx_full;
  assign rtr.rtr_out_valid = reset_n
                           & (tx_count != '0);
  assign rtr.rtr_out_data  = rtr.rtr_out_valid
                           ? tx_mem[tx_rd_ptr]
                           : '0;

  // ---------------- RX FIFO ----------------
  pkt_t             rx_mem [RX_FIFO_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;
  logic             rx_full;
  logic             rx_push;
  logic             rx_pop;
  pkt_t             rx_head;

  assign rx_full = rx_count == RX_CW'(RX_FIFO_DEPTH);
  assign rx_pop  = message_in_read
                 & message_in_valid;
  assign rx_push = rtr.rtr_in_valid
                 & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_wr_ptr            <= '0;
      rx_rd_ptr            <= '0;
      rx_count             <= '0;
      rx_overflow          <= 1'b0;
      message_in_available <= 1'b0;
    end else begin
      if (rx_push)
        rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)
        rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      rx_count <= rx_count + RX_CW'(rx_push)
                           - RX_CW'(rx_pop);
      if (rtr.rtr_in_valid && !rx_push)
        rx_overflow <= 1'b1;
      message_in_available <= message_in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wr_ptr] <= pkt_t'(rtr.rtr_in_data);
  end

  assign message_in_valid = reset_n
                          & (rx_count != '0);
  assign rx_head = message_in_valid
                 ? rx_mem[rx_rd_ptr]
                 : '0;

  assign node_in_multicast_group = rx_head.multicast_group;
  assign node_in_done_flag       = rx_head.done_flag;
  assign node_in_result_flag     = rx_head.result_flag;
  assign node_in_matrix_type     = rx_head.matrix_type;
  assign node_in_matrix_x_coord  = rx_head.matrix_x_coord;
  assign node_in_matrix_y_coord  = rx_head.matrix_y_coord;
  assign node_in_matrix_element  = rx_head.matrix_element;

  // Destination coords name this node; the node never sees them.
  logic unused_rx_dest;
  assign unused_rx_dest = ^{rx_head.x_coord, rx_head.y_coord};

endmodule
